// File: rtl/alu_secuencial.sv
// Multi-cycle ANCHO-bit ALU with iterative shift-add multiply and restoring divide.
// Define ALU_BANDERA_V_EN to add the signed-overflow output banderaV.
module alu_secuencial #(
    parameter  int ANCHO = 8,
    localparam int CTR_W = $clog2(ANCHO + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inicio,
    input  logic [2:0]           Codigo_OP,
    input  logic [ANCHO-1:0]     Dato0,
    input  logic [ANCHO-1:0]     Dato1,
    output logic                 ocupado,
    output logic                 listo,
    output logic [2*ANCHO-1:0]   Resultado,
    output logic                 banderaA,
    output logic                 banderaB,
    output logic                 banderaE
`ifdef ALU_BANDERA_V_EN
    ,
    output logic                 banderaV
`endif
);

    typedef enum logic [1:0] {REPOSO, CALCULO, FIN} estado_e;
    typedef enum logic [2:0] {
        OP_SUM = 3'b000, OP_RES = 3'b001, OP_PRO = 3'b010, OP_DIV = 3'b011,
        OP_MOD = 3'b100, OP_AND = 3'b101, OP_OR  = 3'b110, OP_XOR = 3'b111
    } op_e;

    estado_e            estado;
    op_e                op_r;
    logic [ANCHO-1:0]   a_r, b_r;
    // alto:bajo is the shared product / remainder:quotient register pair.
    logic [ANCHO-1:0]   alto, bajo;
    logic [CTR_W-1:0]   contador;

    logic [ANCHO:0]     suma, resta, paso_mul, desplazado, paso_div;
    logic [2*ANCHO-1:0] res_fin;
    logic               bandera_a_fin, error_fin, v_fin, arranca_iter;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        suma          = {1'b0, a_r} + {1'b0, b_r};
        resta         = {1'b0, a_r} - {1'b0, b_r};
        paso_mul      = {1'b0, alto} + (bajo[0] ? {1'b0, a_r} : {(ANCHO+1){1'b0}});
        desplazado    = {alto, bajo[ANCHO-1]};
        paso_div      = desplazado - {1'b0, b_r};
        res_fin       = '0;
        bandera_a_fin = 1'b0;
        error_fin     = 1'b0;
        v_fin         = 1'b0;
        unique case (op_r)
            OP_SUM: begin
                res_fin       = {{(ANCHO-1){1'b0}}, suma};
                bandera_a_fin = suma[ANCHO];
                v_fin = (a_r[ANCHO-1] == b_r[ANCHO-1]) && (suma[ANCHO-1] != a_r[ANCHO-1]);
            end
            OP_RES: begin
                res_fin       = {{ANCHO{1'b0}}, resta[ANCHO-1:0]};
                bandera_a_fin = resta[ANCHO];
                v_fin = (a_r[ANCHO-1] != b_r[ANCHO-1]) && (resta[ANCHO-1] != a_r[ANCHO-1]);
            end
            OP_PRO: res_fin = {alto, bajo};
            OP_DIV: begin
                error_fin = (b_r == '0);
                res_fin   = error_fin ? '1 : {{ANCHO{1'b0}}, bajo};
            end
            OP_MOD: begin
                error_fin = (b_r == '0);
                res_fin   = {{ANCHO{1'b0}}, error_fin ? a_r : alto};
            end
            OP_AND: res_fin = {{ANCHO{1'b0}}, a_r & b_r};
            OP_OR:  res_fin = {{ANCHO{1'b0}}, a_r | b_r};
            OP_XOR: res_fin = {{ANCHO{1'b0}}, a_r ^ b_r};
        endcase
    end

    assign arranca_iter = (Codigo_OP == OP_PRO) ||
                          (((Codigo_OP == OP_DIV) || (Codigo_OP == OP_MOD)) && (Dato1 != '0));

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado    <= REPOSO;
            op_r      <= OP_SUM;
            a_r       <= '0;
            b_r       <= '0;
            alto      <= '0;
            bajo      <= '0;
            contador  <= '0;
            ocupado   <= 1'b0;
            listo     <= 1'b0;
            Resultado <= '0;
            banderaA  <= 1'b0;
            banderaB  <= 1'b0;
            banderaE  <= 1'b0;
`ifdef ALU_BANDERA_V_EN
            banderaV  <= 1'b0;
`endif
        end else begin
            listo <= 1'b0;
            unique case (estado)
                REPOSO: begin
                    if (inicio) begin
                        op_r     <= op_e'(Codigo_OP);
                        a_r      <= Dato0;
                        b_r      <= Dato1;
                        alto     <= '0;
                        bajo     <= (Codigo_OP == OP_PRO) ? Dato1 : Dato0;
                        contador <= '0;
                        ocupado  <= 1'b1;
                        estado   <= arranca_iter ? CALCULO : FIN;
                    end
                end
                CALCULO: begin
                    contador <= contador + 1'b1;
                    if (op_r == OP_PRO) begin
                        alto <= paso_mul[ANCHO:1];
                        bajo <= {paso_mul[0], bajo[ANCHO-1:1]};
                    end else if (!paso_div[ANCHO]) begin
                        alto <= paso_div[ANCHO-1:0];
                        bajo <= {bajo[ANCHO-2:0], 1'b1};
                    end else begin
                        alto <= desplazado[ANCHO-1:0];
                        bajo <= {bajo[ANCHO-2:0], 1'b0};
                    end
                    if (contador == CTR_W'(ANCHO - 1))
                        estado <= FIN;
                end
                FIN: begin
                    Resultado <= res_fin;
                    banderaA  <= bandera_a_fin;
                    // A divide-by-zero never reports zero, even for MOD 0/0.
                    banderaB  <= (res_fin == '0) && !error_fin;
                    banderaE  <= error_fin;
`ifdef ALU_BANDERA_V_EN
                    banderaV  <= v_fin;
`endif
                    listo     <= 1'b1;
                    ocupado   <= 1'b0;
                    estado    <= REPOSO;
                end
                default: estado <= REPOSO;
            endcase
        end
    end

`ifndef ALU_BANDERA_V_EN
    logic unused_v;
    assign unused_v = v_fin;
`endif

endmodule

// File: tb/tb_alu_secuencial.sv
// Randomized self-checking bench for alu_secuencial (ANCHO=8) against an arithmetic reference model.
module tb_alu_secuencial;

    localparam int ANCHO = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 inicio;
    logic [2:0]           Codigo_OP;
    logic [ANCHO-1:0]     Dato0, Dato1;
    logic                 ocupado, listo;
    logic [2*ANCHO-1:0]   Resultado;
    logic                 banderaA, banderaB, banderaE;
`ifdef ALU_BANDERA_V_EN
    logic                 banderaV;
`endif

    int n_cmp = 0;
    int n_err = 0;

    alu_secuencial #(.ANCHO(ANCHO)) dut (
        .clk       (clk),
        .rst       (rst),
        .inicio    (inicio),
        .Codigo_OP (Codigo_OP),
        .Dato0     (Dato0),
        .Dato1     (Dato1),
        .ocupado   (ocupado),
        .listo     (listo),
        .Resultado (Resultado),
        .banderaA  (banderaA),
        .banderaB  (banderaB),
        .banderaE  (banderaE)
`ifdef ALU_BANDERA_V_EN
        ,
        .banderaV  (banderaV)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic over the unsigned/signed operand values.
    task automatic modelo(input logic [2:0] op, input int a, input int b,
                          output logic [15:0] r, output logic fa, output logic fb,
                          output logic fe, output logic fv, output int lat);
        int sa, sb, t;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        fa = 1'b0; fe = 1'b0; fv = 1'b0; lat = 1; r = '0;
        case (op)
            3'd0: begin t = a + b; r = 16'(t); fa = (t > 255); fv = (sa + sb > 127) || (sa + sb < -128); end
            3'd1: begin t = (a - b + 256) % 256; r = 16'(t); fa = (a < b); fv = (sa - sb > 127) || (sa - sb < -128); end
            3'd2: begin r = 16'(a * b); lat = 9; end
            3'd3: if (b == 0) begin r = 16'hFFFF; fe = 1'b1; end else begin r = 16'(a / b); lat = 9; end
            3'd4: if (b == 0) begin r = 16'(a); fe = 1'b1; end else begin r = 16'(a % b); lat = 9; end
            3'd5: r = 16'(a & b);
            3'd6: r = 16'(a | b);
            default: r = 16'(a ^ b);
        endcase
        fb = (r == 16'd0) && !fe;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input bit revolver, input bit molestar);
        logic [15:0] r;
        logic fa, fb, fe, fv;
        int lat, ciclos;
        string p;
        modelo(op, int'(a), int'(b), r, fa, fb, fe, fv, lat);
        p = $sformatf("op%0d %0h,%0h", op, a, b);
        @(negedge clk);
        Codigo_OP = op; Dato0 = a; Dato1 = b; inicio = 1'b1;
        @(posedge clk);
        #1 inicio = 1'b0;
        ciclos = 0;
        do begin
            @(posedge clk);
            #1 ciclos++;
            if (!listo) begin
                check({p, " ocupado"}, 32'(ocupado), 32'd1);
                if (revolver) {Codigo_OP, Dato0, Dato1} = 19'($urandom);
                if (molestar) inicio = (ciclos == 2);
            end
        end while (!listo && ciclos < 40);
        inicio = 1'b0;
        check({p, " latency"}, 32'(ciclos), 32'(lat));
        check({p, " Resultado"}, 32'(Resultado), 32'(r));
        check({p, " banderaA"}, 32'(banderaA), 32'(fa));
        check({p, " banderaB"}, 32'(banderaB), 32'(fb));
        check({p, " banderaE"}, 32'(banderaE), 32'(fe));
`ifdef ALU_BANDERA_V_EN
        check({p, " banderaV"}, 32'(banderaV), 32'(fv));
`endif
        @(posedge clk);
        #1;
        check({p, " listo pulse"}, 32'(listo), 32'd0);
        check({p, " hold"}, 32'(Resultado), 32'(r));
    endtask

    initial begin
        int pulsos;
        logic [2:0] op;
        logic [7:0] a, b;
        rst = 1'b1; inicio = 1'b0; Codigo_OP = '0; Dato0 = '0; Dato1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ocupado", 32'(ocupado), 32'd0);
        check("reset listo", 32'(listo), 32'd0);
        check("reset Resultado", 32'(Resultado), 32'd0);
        check("reset flags", 32'({banderaA, banderaB, banderaE}), 32'd0);
        @(negedge clk) rst = 1'b0;

        run_op(3'd0, 8'd200, 8'd100, 1'b0, 1'b0);

        // Abort a PRO with reset two cycles into the iteration.
        @(negedge clk);
        Codigo_OP = 3'd2; Dato0 = 8'hFF; Dato1 = 8'hFF; inicio = 1'b1;
        @(posedge clk);
        #1 inicio = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort ocupado", 32'(ocupado), 32'd0);
        check("abort Resultado", 32'(Resultado), 32'd0);
        check("abort flags", 32'({banderaA, banderaB, banderaE}), 32'd0);
        @(negedge clk) rst = 1'b0;
        pulsos = 0;
        repeat (15) begin
            @(posedge clk);
            #1 if (listo) pulsos++;
        end
        check("abort no listo", 32'(pulsos), 32'd0);

        run_op(3'd0, 8'd200, 8'd100, 1'b0, 1'b0);
        run_op(3'd1, 8'd5,   8'd7,   1'b0, 1'b0);
        run_op(3'd2, 8'd200, 8'd200, 1'b1, 1'b0);
        run_op(3'd3, 8'd200, 8'd7,   1'b1, 1'b0);
        run_op(3'd4, 8'd200, 8'd7,   1'b0, 1'b0);
        run_op(3'd3, 8'd5,   8'd0,   1'b0, 1'b0);
        run_op(3'd4, 8'd5,   8'd0,   1'b0, 1'b0);
        run_op(3'd5, 8'hF0,  8'h3C,  1'b0, 1'b0);
        run_op(3'd7, 8'hAA,  8'hAA,  1'b0, 1'b0);
        run_op(3'd2, 8'hFF,  8'hFF,  1'b0, 1'b1);
        run_op(3'd4, 8'd0,   8'd0,   1'b0, 1'b0);
        run_op(3'd0, 8'h64,  8'h64,  1'b0, 1'b0);
        run_op(3'd1, 8'h80,  8'h01,  1'b0, 1'b0);
        run_op(3'd5, 8'h80,  8'h80,  1'b0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            run_op(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_secuencial.md
Name: alu_secuencial

Overview:
- Parametrised, multi-cycle successor to the team's 8-bit combinational ALU.
- Supports the same eight operations at ANCHO-bit width: SUM, RES, PRO, DIV, MOD, AND, OR, XOR.
- Multiply, divide and modulo use iterative shift-add and restoring shift-subtract datapaths. A start/done handshake connects it to the datapath sequencer.
- Adds registered outputs, a busy indication and a divide-by-zero error flag.

Parameters:
- ANCHO, 8: operand width in bits (>=2). Resultado is 2*ANCHO bits.
- CTR_W, $clog2(ANCHO+1): iteration counter width (derived, not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- inicio  in  1  start request; sampled only in REPOSO.
- Codigo_OP  in  3  000 SUM, 001 RES, 010 PRO, 011 DIV, 100 MOD, 101 AND, 110 OR, 111 XOR.
- Dato0  in  ANCHO  operand A (unsigned).
- Dato1  in  ANCHO  operand B (unsigned).
- ocupado  out  1  high while an operation is in flight.
- listo  out  1  one-cycle pulse when the results are valid.
- Resultado  out  2*ANCHO  result, held until the next completion.
- banderaA  out  1  carry (SUM) / borrow (RES); 0 for all other operations.
- banderaB  out  1  zero flag: Resultado == 0.
- banderaE  out  1  divide-by-zero error (DIV/MOD with Dato1 == 0).

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0, FSM in REPOSO, internal registers 0.
- Reset mid-operation: the operation is aborted and no listo is issued.
- FSM states:
  - REPOSO: idle; ocupado=0.
  - CALCULO: iterating; ocupado=1.
  - FIN: one cycle; writes the outputs and pulses listo.
- REPOSO transitions on inicio=1:
  - Codigo_OP, Dato0 and Dato1 are latched into internal registers. Later input changes are ignored.
  - PRO, and DIV/MOD with Dato1 != 0, go to CALCULO with counter=0.
  - All other cases go directly to FIN.
- CALCULO: one partial step per cycle. After ANCHO steps (counter == ANCHO-1) the FSM goes to FIN.
- FIN: Resultado and flags are updated, listo=1 for exactly one cycle, then the FSM returns to REPOSO.
- Latency (inicio sampled at edge 0):
  - Single-cycle ops and divide-by-zero: listo high after edge 1.
  - PRO/DIV/MOD: listo high after edge ANCHO+1.
- inicio while ocupado=1 is ignored. There is no queueing.
- A new request may be accepted on the edge following listo.
- Arithmetic:
  - SUM: Resultado = zero-extended (ANCHO+1)-bit sum; banderaA = sum bit ANCHO.
  - RES: Resultado = zero-extended low ANCHO bits of Dato0 - Dato1 (modulo 2^ANCHO); banderaA = (Dato0 < Dato1).
  - PRO: full 2*ANCHO-bit unsigned product.
  - DIV: quotient, zero-extended.
  - MOD: remainder, zero-extended.
  - AND/OR/XOR: bitwise result, zero-extended.
- Divide by zero (DIV/MOD with Dato1 == 0):
  - No iteration is performed.
  - DIV: Resultado = all ones (2*ANCHO bits).
  - MOD: Resultado = zero-extended Dato0.
  - banderaE=1 and banderaB=0.
- Flag updates: banderaE is cleared on every non-error completion. banderaB is recomputed from the new Resultado at every completion. All flags are written only in FIN.
- Between completions: Resultado and all flags hold their values. They are not cleared at the start of a new operation.

Optional Feature:
- Macro: ALU_BANDERA_V_EN.
- When defined:
  - Adds output port banderaV (1 bit, reset 0): two's-complement signed overflow of the ANCHO-bit operands.
  - SUM: set when the operands have equal signs and the sign of the low ANCHO bits of the sum differs from them.
  - RES: set when the operands have different signs and the result sign differs from Dato0.
  - All other operations: 0.
  - Updated in FIN only.
- When undefined: port and logic are absent; everything else is unchanged.

Test Plan (ANCHO=8):
- Reset mid-operation: rst high 2 cycles, then inicio PRO 0xFF*0xFF; assert rst at cycle 3 -> outputs 0, ocupado=0, no listo pulse; next operation completes normally.
- SUM 200+100 -> listo 1 cycle after inicio, Resultado=0x012C, banderaA=1, banderaB=0. RES 5-7 -> Resultado=0x00FE, banderaA=1.
- PRO 200*200 -> listo at cycle 9, Resultado=0x9C40, banderaB=0. Dato0/Dato1 changed during CALCULO does not affect the result.
- DIV 200/7 -> Resultado=0x001C at cycle 9. MOD 200/7 -> 0x0004. DIV 5/0 -> Resultado=0xFFFF, banderaE=1 after 1 cycle. MOD 5/0 -> 0x0005, banderaE=1. Next valid operation clears banderaE.
- XOR 0xAA^0xAA -> Resultado=0, banderaB=1. inicio pulsed during a busy PRO is ignored: exactly one listo, and ocupado never drops early.
- With ALU_BANDERA_V_EN: SUM 0x64+0x64 -> banderaV=1. RES 0x80-0x01 -> banderaV=1. AND -> banderaV=0.
